fetch_issue_unit: RTL

Fetch-side producer for the fetch/decode pipeline register. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a small prefetch queue and presents them to the decode-stage register as instr/pc_plus4, which that register latches when not stalled. Also handles branch redirects from decode by flushing queued and in-flight fetches.

---
 rtl/fetch_issue_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_issue_unit.sv
// Fetch-side producer: one outstanding imem request, prefetch queue, redirect flush.
// Optional FETCH_PERF_EN adds saturating stall-cycle and redirect counters.
module fetch_issue_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        pc_src_d,
   input  logic [31:0] pc_branch_d,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        valid_f,
   output logic [31:0] instr_f,
   output logic [31:0] pc_plus4_f
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [15:0] perf_redirects
`endif
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e        r_state, w_state_nxt;
   logic [31:0]   r_pc, w_pc_nxt;
   logic          r_req, w_req_nxt;
   logic [31:0]   r_addr, w_addr_nxt;
   logic [31:0]   r_q_instr [QDEPTH];
   logic [31:0]   r_q_pc4   [QDEPTH];
   logic [PW-1:0] r_rd_ptr, r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_push, w_pop, w_space, w_valid;

   assign w_valid = (r_count != '0);
   assign w_space = (r_count < CW'(QDEPTH));
   assign w_pop   = w_valid & ~stall_f & ~pc_src_d;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_push      = 1'b0;
      case (r_state)
         StIdle: begin
            if (pc_src_d) begin
               w_pc_nxt = pc_branch_d;
            end else if (w_space) begin
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_pc;
               w_state_nxt = StWait;
            end
         end
         StWait: begin
            if (pc_src_d) begin
               w_pc_nxt = pc_branch_d;
               // A redirect coinciding with the ack drops the word and frees the bus now.
               if (imem_ack) begin
                  w_req_nxt   = 1'b0;
                  w_state_nxt = StIdle;
               end else begin
                  w_state_nxt = StDrop;
               end
            end else if (imem_ack) begin
               w_push      = 1'b1;
               w_pc_nxt    = r_pc + 32'd4;
               w_req_nxt   = 1'b0;
               w_state_nxt = StIdle;
            end
         end
         StDrop: begin
            if (pc_src_d) begin
               w_pc_nxt = pc_branch_d;
            end
            if (imem_ack) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (pc_src_d) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while counted as valid.
   always_ff @(posedge clk) begin
      if (w_push && !pc_src_d) begin
         r_q_instr[r_wr_ptr] <= imem_rdata;
         r_q_pc4[r_wr_ptr]   <= r_addr + 32'd4;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign valid_f    = w_valid;
   assign instr_f    = w_valid ? r_q_instr[r_rd_ptr] : 32'h0000_0000;
   assign pc_plus4_f = w_valid ? r_q_pc4[r_rd_ptr] : 32'h0000_0000;

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_stall;
   logic [15:0] r_perf_redir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall <= '0;
         r_perf_redir <= '0;
      end else begin
         if (w_valid && stall_f && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (pc_src_d && (r_perf_redir != '1)) begin
            r_perf_redir <= r_perf_redir + 16'd1;
         end
      end
   end

   assign perf_stall_cyc = r_perf_stall;
   assign perf_redirects = r_perf_redir;
`endif

endmodule
